// File: rtl/cache_pkg.sv
// Shared types and width helpers for the associative byte cache.
package cache_pkg;

    localparam int unsigned BYTE_WIDTH = 8;

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_BUSY = 1'b1
    } fill_state_t;

    // Index width that never collapses to zero bits.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cache_way.sv
// One cache line: valid bit, tag, byte array, async read and tag compare.
module cache_way
    import cache_pkg::*;
#(
    parameter int unsigned TAG_WIDTH    = 13,
    parameter int unsigned OFFSET_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TAG_WIDTH-1:0]    lookup_tag,
    input  logic [OFFSET_WIDTH-1:0] lookup_off,
    input  logic                    byte_we,
    input  logic [OFFSET_WIDTH-1:0] wr_off,
    input  logic [BYTE_WIDTH-1:0]   wr_data,
    input  logic                    tag_we,
    input  logic [TAG_WIDTH-1:0]    wr_tag,
    input  logic                    valid_set,
    input  logic                    valid_clr,
    output logic                    valid,
    output logic                    hit_c,
    output logic [BYTE_WIDTH-1:0]   rdata_c
);

    localparam int unsigned DEPTH = 1 << OFFSET_WIDTH;

    logic [TAG_WIDTH-1:0]  tag;
    logic [BYTE_WIDTH-1:0] data [DEPTH];

    // Valid bit: reset and clear dominate set.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (valid_clr) begin
            valid <= 1'b0;
        end else if (valid_set) begin
            valid <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag <= wr_tag;
        end
        if (byte_we) begin
            data[wr_off] <= wr_data;
        end
    end

    assign hit_c   = valid && (tag == lookup_tag);
    assign rdata_c = data[lookup_off];

endmodule

// File: rtl/cache_assoc.sv
// Fully associative byte cache with line-fill sequencer and round-robin replacement.
module cache_assoc
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned BLOCK_SIZE = 8,
    parameter int unsigned WAYS       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    input  logic                  flush,
    output logic                  hit,
    output logic [7:0]            rdata,
    output logic                  busy,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata
);

    localparam int unsigned OFFSET_WIDTH = safe_clog2(BLOCK_SIZE);
    localparam int unsigned TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH;
    localparam int unsigned WAY_WIDTH    = safe_clog2(WAYS);

    logic [TAG_WIDTH-1:0]    req_tag;
    logic [OFFSET_WIDTH-1:0] req_off;

    fill_state_t             state, state_nxt;
    logic [TAG_WIDTH-1:0]    fill_tag, fill_tag_nxt;
    logic [OFFSET_WIDTH-1:0] fill_cnt, fill_cnt_nxt;
    logic [WAY_WIDTH-1:0]    victim, victim_nxt;
    logic                    victim_by_ptr, victim_by_ptr_nxt;
    logic [WAY_WIDTH-1:0]    victim_ptr, victim_ptr_nxt;
    logic                    mem_req_nxt;
    logic [ADDR_WIDTH-1:0]   mem_addr_nxt;

    logic [WAYS-1:0]         way_valid;
    logic [WAYS-1:0]         way_hit;
    logic [BYTE_WIDTH-1:0]   way_rdata [WAYS];
    logic [WAYS-1:0]         way_byte_we;
    logic [WAYS-1:0]         way_tag_we;
    logic [WAYS-1:0]         way_valid_set;
    logic [WAYS-1:0]         way_valid_clr;
    logic [OFFSET_WIDTH-1:0] wr_off;
    logic [BYTE_WIDTH-1:0]   wr_data;

    logic                    inv_found;
    logic [WAY_WIDTH-1:0]    inv_idx;

    assign req_tag = addr[ADDR_WIDTH-1:OFFSET_WIDTH];
    assign req_off = addr[OFFSET_WIDTH-1:0];
    assign busy    = (state == FILL_BUSY);

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        cache_way #(
            .TAG_WIDTH   (TAG_WIDTH),
            .OFFSET_WIDTH(OFFSET_WIDTH)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .lookup_tag(req_tag),
            .lookup_off(req_off),
            .byte_we   (way_byte_we[g]),
            .wr_off    (wr_off),
            .wr_data   (wr_data),
            .tag_we    (way_tag_we[g]),
            .wr_tag    (fill_tag),
            .valid_set (way_valid_set[g]),
            .valid_clr (way_valid_clr[g]),
            .valid     (way_valid[g]),
            .hit_c     (way_hit[g]),
            .rdata_c   (way_rdata[g])
        );
    end

    // Lookup result: at most one way matches, so an AND-OR mux suffices.
    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            rdata = rdata | (way_rdata[i] & {BYTE_WIDTH{way_hit[i]}});
        end
    end

    assign hit = |way_hit;

    // Lowest-index invalid way, preferred over the round-robin pointer.
    always_comb begin
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!way_valid[i] && !inv_found) begin
                inv_found = 1'b1;
                inv_idx   = WAY_WIDTH'(i);
            end
        end
    end

    // Next-state, fill sequencing and way write controls.
    always_comb begin
        state_nxt         = state;
        fill_tag_nxt      = fill_tag;
        fill_cnt_nxt      = fill_cnt;
        victim_nxt        = victim;
        victim_by_ptr_nxt = victim_by_ptr;
        victim_ptr_nxt    = victim_ptr;
        mem_req_nxt       = mem_req;
        mem_addr_nxt      = mem_addr;
        way_byte_we       = '0;
        way_tag_we        = '0;
        way_valid_set     = '0;
        way_valid_clr     = '0;
        wr_off            = req_off;
        wr_data           = wdata;

        case (state)
            FILL_IDLE: begin
                if (flush) begin
                    way_valid_clr = '1;
                end else if (rd_req) begin
                    if (!hit) begin
                        fill_tag_nxt      = req_tag;
                        victim_nxt        = inv_found ? inv_idx : victim_ptr;
                        victim_by_ptr_nxt = !inv_found;
                        way_valid_clr[victim_nxt] = 1'b1;
                        fill_cnt_nxt      = '0;
                        mem_req_nxt       = 1'b1;
                        mem_addr_nxt      = {req_tag, {OFFSET_WIDTH{1'b0}}};
                        state_nxt         = FILL_BUSY;
                    end
                end else if (wr_req && hit) begin
                    way_byte_we = way_hit;
                end
            end
            FILL_BUSY: begin
                wr_off  = fill_cnt;
                wr_data = mem_rdata;
                if (flush) begin
                    way_valid_clr = '1;
                    mem_req_nxt   = 1'b0;
                    state_nxt     = FILL_IDLE;
                end else if (mem_ack) begin
                    way_byte_we[victim] = 1'b1;
                    fill_cnt_nxt        = fill_cnt + OFFSET_WIDTH'(1);
                    mem_addr_nxt        = {fill_tag, fill_cnt_nxt};
                    if (fill_cnt == OFFSET_WIDTH'(BLOCK_SIZE - 1)) begin
                        way_tag_we[victim]    = 1'b1;
                        way_valid_set[victim] = 1'b1;
                        mem_req_nxt           = 1'b0;
                        state_nxt             = FILL_IDLE;
                        if (victim_by_ptr) begin
                            victim_ptr_nxt = victim_ptr + WAY_WIDTH'(1);
                        end
                    end
                end
            end
            default: begin
                state_nxt = FILL_IDLE;
            end
        endcase
    end

    // Sequencer state and registered memory port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FILL_IDLE;
            fill_tag      <= '0;
            fill_cnt      <= '0;
            victim        <= '0;
            victim_by_ptr <= 1'b0;
            victim_ptr    <= '0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
        end else begin
            state         <= state_nxt;
            fill_tag      <= fill_tag_nxt;
            fill_cnt      <= fill_cnt_nxt;
            victim        <= victim_nxt;
            victim_by_ptr <= victim_by_ptr_nxt;
            victim_ptr    <= victim_ptr_nxt;
            mem_req       <= mem_req_nxt;
            mem_addr      <= mem_addr_nxt;
        end
    end

endmodule

// File: tb/tb_cache_assoc.sv
// Self-checking bench for cache_assoc: directed table, corner sequences, random traffic.
module tb_cache_assoc;

    localparam int unsigned AW = 16;
    localparam int unsigned BS = 8;
    localparam int unsigned NW = 4;

    logic        clk;
    logic        rst;
    logic        rd_req;
    logic        wr_req;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        flush;
    logic        hit;
    logic [7:0]  rdata;
    logic        busy;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    cache_assoc #(
        .ADDR_WIDTH(AW),
        .BLOCK_SIZE(BS),
        .WAYS      (NW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .addr     (addr),
        .wdata    (wdata),
        .flush    (flush),
        .hit      (hit),
        .rdata    (rdata),
        .busy     (busy),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert (!(rd_req && wr_req)) else $error("rd_req and wr_req asserted together");
    end

    int total = 0;
    int bad   = 0;

    // Reference model: which tag sits in which way, its bytes, and the replacement pointer.
    bit          m_valid [NW];
    logic [12:0] m_tag   [NW];
    logic [7:0]  m_data  [NW][BS];
    int          m_ptr;

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [7:0]  d;
        bit          exp_hit;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vt [6];

    function automatic logic [7:0] memfn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h82;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < NW; i++) m_valid[i] = 1'b0;
    endtask

    task automatic m_find(input logic [15:0] a, output bit h, output int w);
        h = 1'b0;
        w = 0;
        for (int i = 0; i < NW; i++) begin
            if (m_valid[i] && m_tag[i] == a[15:3]) begin
                h = 1'b1;
                w = i;
            end
        end
    endtask

    task automatic m_fill(input logic [12:0] t);
        int w;
        w = -1;
        for (int i = 0; i < NW; i++) begin
            if (!m_valid[i] && w < 0) w = i;
        end
        if (w < 0) begin
            w     = m_ptr;
            m_ptr = (m_ptr + 1) % NW;
        end
        for (int j = 0; j < BS; j++) m_data[w][j] = memfn({t, 3'(j)});
        m_tag[w]   = t;
        m_valid[w] = 1'b1;
    endtask

    task automatic peek(input string name, input logic [15:0] a, input bit exp_h);
        addr = a;
        #1;
        chk(name, hit, exp_h);
    endtask

    // Read; on a miss, serve the line fill with `gap` idle cycles before every ack.
    task automatic do_read(input logic [15:0] a, input int gap);
        bit          h;
        int          w;
        logic [12:0] t;
        logic [15:0] exp_a;
        t = a[15:3];
        m_find(a, h, w);
        @(negedge clk);
        rd_req = 1'b1;
        addr   = a;
        #1;
        chk("rd_hit", hit, h);
        chk("rd_data", rdata, h ? m_data[w][a[2:0]] : 8'h00);
        @(negedge clk);
        rd_req = 1'b0;
        if (!h) begin
            chk("fill_busy", busy, 1);
            for (int i = 0; i < BS; i++) begin
                exp_a = {t, 3'(i)};
                for (int g = 0; g < gap; g++) begin
                    chk("hold_req", mem_req, 1);
                    chk("hold_addr", mem_addr, exp_a);
                    @(negedge clk);
                end
                chk("fill_req", mem_req, 1);
                chk("fill_addr", mem_addr, exp_a);
                chk("fill_not_valid", hit, 0);
                mem_ack   = 1'b1;
                mem_rdata = memfn(exp_a);
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = 8'h00;
            end
            m_fill(t);
            m_find(a, h, w);
            chk("fill_done_busy", busy, 0);
            chk("fill_done_req", mem_req, 0);
            chk("fill_done_hit", hit, 1);
            chk("fill_done_data", rdata, m_data[w][a[2:0]]);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        bit h;
        int w;
        m_find(a, h, w);
        @(negedge clk);
        wr_req = 1'b1;
        addr   = a;
        wdata  = d;
        #1;
        chk("wr_hit", hit, h);
        @(negedge clk);
        wr_req = 1'b0;
        if (h) m_data[w][a[2:0]] = d;
        chk("wr_no_req", mem_req, 0);
        chk("wr_no_busy", busy, 0);
        chk("wr_after_hit", hit, h);
        if (h) chk("wr_after_data", rdata, d);
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        m_clear();
        chk("flush_busy", busy, 0);
        chk("flush_req", mem_req, 0);
    endtask

    // Start a miss on `a` and deliver `nacks` bytes, leaving the fill in progress.
    task automatic start_partial(input logic [15:0] a, input int nacks);
        @(negedge clk);
        rd_req = 1'b1;
        addr   = a;
        @(negedge clk);
        rd_req = 1'b0;
        for (int i = 0; i < nacks; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = memfn({a[15:3], 3'(i)});
            @(negedge clk);
            mem_ack = 1'b0;
        end
        chk("partial_busy", busy, 1);
    endtask

    initial begin
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wdata = '0;
        flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        m_clear();
        m_ptr = 0;

        vt[0] = '{1'b0, 16'h1230, 8'h00, 1'b1, 8'hA0};
        vt[1] = '{1'b0, 16'h1237, 8'h00, 1'b1, 8'hA7};
        vt[2] = '{1'b1, 16'h1232, 8'h5A, 1'b1, 8'hA2};
        vt[3] = '{1'b0, 16'h1232, 8'h00, 1'b1, 8'h5A};
        vt[4] = '{1'b1, 16'h2000, 8'h77, 1'b0, 8'h00};
        vt[5] = '{1'b0, 16'h1235, 8'h00, 1'b1, 8'hA5};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_req", mem_req, 0);
        chk("reset_addr", mem_addr, 16'h0000);
        peek("reset_miss", 16'h1234, 1'b0);

        // First fill: bytes 0xA0..0xA7, word at offset 4 is 0xA4.
        do_read(16'h1234, 0);
        chk("first_fill_rdata", rdata, 8'hA4);

        // Directed table on the freshly filled line.
        for (int i = 0; i < 6; i++) begin
            bit h;
            int w;
            @(negedge clk);
            addr   = vt[i].a;
            wdata  = vt[i].d;
            rd_req = !vt[i].wr;
            wr_req = vt[i].wr;
            #1;
            chk($sformatf("vec%0d_hit", i), hit, vt[i].exp_hit);
            chk($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rdata);
            @(negedge clk);
            rd_req = 1'b0;
            wr_req = 1'b0;
            chk($sformatf("vec%0d_no_req", i), mem_req, 0);
            m_find(vt[i].a, h, w);
            if (vt[i].wr && h) m_data[w][vt[i].a[2:0]] = vt[i].d;
        end

        // Flush while idle drops the cached line.
        do_flush();
        peek("flush_idle_miss", 16'h1230, 1'b0);

        // Five lines into four ways: the fifth evicts way 0.
        for (int k = 0; k < 5; k++) do_read(16'(k << 8), 0);
        peek("evict_0000_miss", 16'h0000, 1'b0);
        peek("evict_0100_hit", 16'h0100, 1'b1);
        peek("evict_0400_hit", 16'h0400, 1'b1);

        // Slow memory: three idle cycles before every ack.
        do_read(16'h0503, 3);

        // Flush after the third ack, with an ack on the same edge.
        start_partial(16'h0600, 3);
        flush   = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        mem_ack = 1'b0;
        m_clear();
        chk("abort_req", mem_req, 0);
        chk("abort_busy", busy, 0);
        peek("abort_partial_miss", 16'h0600, 1'b0);
        peek("abort_0200_miss", 16'h0200, 1'b0);
        peek("abort_0500_miss", 16'h0500, 1'b0);
        @(negedge clk);
        chk("abort_req_stays", mem_req, 0);

        // Reset in the middle of a fill.
        do_read(16'h0700, 0);
        start_partial(16'h0800, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_clear();
        m_ptr = 0;
        chk("rst_fill_req", mem_req, 0);
        chk("rst_fill_busy", busy, 0);
        chk("rst_fill_addr", mem_addr, 16'h0000);
        peek("rst_partial_miss", 16'h0800, 1'b0);
        peek("rst_0700_miss", 16'h0700, 1'b0);

        // Random traffic over ten lines so hits, misses and evictions all occur.
        for (int n = 0; n < 300; n++) begin
            int          r;
            logic [15:0] a;
            r = int'($urandom_range(0, 19));
            a = 16'h3000 + 16'(($urandom_range(0, 9) << 3) | $urandom_range(0, 7));
            if (r < 1) begin
                do_flush();
            end else if (r < 8) begin
                do_write(a, 8'($urandom));
            end else begin
                do_read(a, int'($urandom_range(0, 2)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_assoc.md
Name: cache_assoc

Overview:
- Parametrised successor to the single-line byte cache.
- Holds WAYS fully associative lines of BLOCK_SIZE bytes each.
- Adds an internal line-fill sequencer with a memory request/acknowledge handshake, round-robin replacement, write-update on hit, and a single-cycle flush.
- Sits between the 6502 core bus and the external/slow memory port. The core stalls while busy is high.

Parameters:
- ADDR_WIDTH, 16, byte address width. Localparam TAG_WIDTH = ADDR_WIDTH - OFFSET_WIDTH.
- BLOCK_SIZE, 8, bytes per line; power of two, >= 2. Localparam OFFSET_WIDTH = $clog2(BLOCK_SIZE).
- WAYS, 4, number of lines; power of two, >= 2. Localparam WAY_WIDTH = $clog2(WAYS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_req  in  1  read request for addr
- wr_req  in  1  write request for addr/wdata (memory write handled outside)
- addr  in  ADDR_WIDTH  byte address; tag = addr[MSB:OFFSET_WIDTH], off = addr[OFFSET_WIDTH-1:0]
- wdata  in  8  write data
- flush  in  1  invalidate all lines
- hit  out  1  addr matches a valid line (combinational)
- rdata  out  8  byte from hit line (combinational, registered outside); 0 when hit=0
- busy  out  1  fill in progress
- mem_req  out  1  byte fetch request
- mem_addr  out  ADDR_WIDTH  fetch address
- mem_ack  in  1  mem_rdata valid; consumed only when mem_req=1
- mem_rdata  in  8  fetched byte

Behaviour:
- Reset (sync, rst=1 at posedge):
  - all valid bits cleared; state IDLE; victim pointer 0.
  - mem_req=0, mem_addr=0, busy=0.
  - Tag/data arrays are not reset.
- hit and rdata are purely combinational from addr, valid and tags. At most one way can match, because allocation happens only on a miss. rdata is AND-OR muxed.
- FSM states:
  - IDLE:
    - flush=1: clear all valid; nothing else happens that cycle, and flush takes priority over rd_req/wr_req.
    - Else wr_req && hit: write wdata into the hit way at off (write-update); valid unchanged.
    - wr_req && !hit: no allocate, no state change.
    - rd_req && hit: no state change.
    - rd_req && !hit:
      - latch fill_tag = tag;
      - select victim = lowest-index invalid way, else the victim pointer;
      - clear victim valid; fill_cnt=0;
      - next state FILL. busy=1 from the next cycle.
    - rd_req and wr_req together: wr_req ignored (protocol violation, assertion in bench).
  - FILL:
    - mem_req=1 and mem_addr={fill_tag, fill_cnt}, both registered and stable until mem_ack.
    - On mem_ack: write mem_rdata to victim[fill_cnt], increment fill_cnt, and update mem_addr in the same edge. mem_req stays high for back-to-back acks.
    - On the ack of byte BLOCK_SIZE-1:
      - write tag, set valid;
      - mem_req=0;
      - advance the victim pointer (wraps WAYS-1 -> 0) only if the victim was chosen by the pointer;
      - go IDLE.
    - hit=1 for the re-presented address on the cycle after returning to IDLE.
    - rd_req/wr_req are ignored while busy.
    - flush during FILL: abort, clear all valid, mem_req=0 next cycle, go IDLE. A pending mem_ack on that same edge is discarded.
- fill_cnt wraps naturally at BLOCK_SIZE. The fill always starts at offset 0; there is no critical-word-first.
- rst mid-FILL: immediate return to the reset state; partial line stays invalid.

Decomposition:
- Package cache_pkg: typedef enum fill_state_t {FILL_IDLE, FILL_BUSY}; plus a clog2-safe width helper constant if needed.
- Sub-module cache_way (one per way, generate loop). It holds:
  - valid, tag, and the BLOCK_SIZE x 8 data array;
  - a write port (byte write, tag write, set/clear valid);
  - async read at off and a hit compare.
- The top holds the FSM, victim selection, mem handshake and the output mux.

Test Plan:
- Reset, then rd_req addr=0x1234 -> hit=0, busy=1 next cycle, mem_addr walks 0x1230..0x1237 with one ack per byte (mem_rdata=0xA0+i). busy falls and hit=1, rdata=0xA4.
- Fill 5 distinct lines (0x0000, 0x0100, 0x0200, 0x0300, 0x0400) with WAYS=4 -> first four use ways 0-3 (invalid-first), fifth evicts way 0. 0x0000 then misses, while 0x0100 still hits.
- wr_req addr=0x1232 wdata=0x5A on a hit line -> following read returns 0x5A; wr_req to an uncached 0x2000 -> no mem_req, hit stays 0.
- mem_ack withheld 3 cycles during fill -> mem_req and mem_addr held stable; the line becomes valid only after the 8th ack.
- flush asserted after the 3rd ack of a fill -> mem_req=0 next cycle, busy=0. All previously valid lines miss, and the partially filled line misses.
- rst asserted mid-fill -> mem_req=0, busy=0 next cycle; no line hits.
